// File: rtl/pattern_10011_tx.sv
// rtl/pattern_10011_tx.sv - serial frame transmitter: sync header, MSB-first payload, idle gap
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   data_in      payload word, captured when valid && ready at a rising edge
//   valid        payload request
//   ready        high only while idle
//   out          registered serial bit stream
//   busy         high while a frame (header, payload or gap) is on out
//   sync_active  high while out carries a header bit
//   done         high while out carries the last payload bit
module pattern_10011_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 5,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 5'b10011,
    parameter int                GAP      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              sync_active,
    output logic              done
);

    localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_V = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int CW    = (MAX_V <= 2) ? 1 : $clog2(MAX_V);

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              out_q, out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              sync_q, sync_d;
    logic              done_q, done_d;

    // State register. Outputs are flopped from the next-state decode so that
    // the first header bit is on out in the cycle right after the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_SYNC;
                    cnt_d   = SYNC_LAST;
                    shift_d = data_in;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                // Bit just sent leaves through the MSB.
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state
    always_comb begin
        out_d   = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        sync_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_SYNC: begin
                out_d  = |(SYNC_PAT & (SYNC_W'(1) << cnt_d));
                busy_d = 1'b1;
                sync_d = 1'b1;
            end
            ST_DATA: begin
                out_d  = shift_d[DATA_W-1];
                busy_d = 1'b1;
                done_d = (cnt_d == '0);
            end
            ST_GAP:  busy_d = 1'b1;
            default: ready_d = 1'b1;
        endcase
    end

    assign ready       = ready_q;
    assign out         = out_q;
    assign busy        = busy_q;
    assign sync_active = sync_q;
    assign done        = done_q;

endmodule

// File: doc/pattern_10011_tx.md
Name: pattern_10011_tx

Overview:
- Serial frame transmitter: the sending side of the 10011 sync-pattern link.
- Accepts a parallel payload word on a valid/ready handshake.
- Emits a 1-bit serial stream per frame: 5-bit sync header 10011, then the payload MSB-first, then a fixed run of idle-zero gap bits.
- Sits upstream of the serial 10011 sync detector/deserializer; the header lets the receiver find frame start.

Parameters:
- DATA_W, 8, payload width in bits (legal: 1..32).
- SYNC_PAT, 5'b10011, sync header, sent MSB-first.
- SYNC_W, 5, sync header width (legal: 1..8).
- GAP, 2, forced zero bits after each payload (legal: 0..15).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset: synchronous, active-low; sampled on the rising edge of clk.
- data_in  input  DATA_W  payload word; captured on handshake.
- valid  input  1  payload request.
- ready  output  1  high only in IDLE; handshake = valid && ready at a rising edge.
- out  output  1  serial bit stream, registered.
- busy  output  1  high in SYNC, DATA and GAP.
- sync_active  output  1  high while out carries a header bit.
- done  output  1  one-cycle pulse while out carries the last payload bit.

Behaviour:
- Reset (rst==0 at an edge):
  - Next state is IDLE: out=0, ready=1, busy=0, sync_active=0, done=0.
  - Bit counter and shift register are cleared.
  - Reset wins over any handshake in the same cycle.
  - Reset mid-frame aborts the frame immediately; the partial frame is not resumed.
- States: IDLE, SYNC, DATA, GAP. Registered Moore outputs decode from state and counter only.
- IDLE:
  - out=0.
  - On handshake at edge T: data_in goes into the shift register; go to SYNC with cnt=SYNC_W-1.
  - valid without a handshake has no effect.
- SYNC:
  - out = SYNC_PAT[cnt]; sync_active=1; cnt decrements.
  - After the bit with cnt==0: go to DATA with cnt=DATA_W-1.
  - For T=handshake edge, header bits appear on out during cycles T+1..T+SYNC_W.
- DATA:
  - out = shift register MSB; shift left one per cycle.
  - done=1 during the cycle cnt==0.
  - Then go to GAP with cnt=GAP-1, or go straight to IDLE if GAP==0.
- GAP:
  - out=0 for GAP cycles, then IDLE.
- Payload capture:
  - Payload is captured only at the handshake.
  - Later changes on data_in, and valid held high while busy, have no effect. ready=0 throughout the frame.
- Frame length: SYNC_W+DATA_W+GAP bits. Minimum spacing between frame starts is SYNC_W+DATA_W+GAP+1 cycles; the one IDLE cycle is the handshake cycle.
- Back-to-back: valid held high re-handshakes on the first IDLE cycle. No bubble beyond that IDLE cycle.
- No bit-stuffing: a payload containing the sync pattern goes out unmodified. Avoiding false sync is the sender's responsibility.
- Counter width: clog2 of max(SYNC_W, DATA_W, GAP), minimum 1 bit. No wrap is reachable in legal configurations.

Test Plan:
- Reset: hold rst=0 3 cycles with valid=1 and data_in=8'hFF -> out=0, ready=1, busy=0 throughout. After release, first handshake one edge later.
- Single frame: data_in=8'hA5, handshake at edge T:
  - out on T+1..T+15 = 1,0,0,1,1, 1,0,1,0,0,1,0,1, 0,0.
  - sync_active high T+1..T+5; done high only at T+13.
  - ready returns high at T+16.
- Hold/ignore: after the 8'hA5 handshake, change data_in to 8'h00 and keep valid=1 -> payload bits still 10100101. A second frame with 8'h00 starts its header at T+17.
- Reset mid-frame: rst=0 at edge T+8 (in DATA) -> out=0, ready=1 from that edge. A fresh handshake with 8'h3C yields the full header then 00111100.
- GAP=0 build, DATA_W=4, valid held high with data_in=4'hF:
  - out = 1,0,0,1,1,1,1,1,1, then one IDLE 0, then repeat.
  - done period is 10 cycles.
- Random: 200 frames with random payloads and random valid gaps. A scoreboard deserializes on sync_active/done and matches every payload in order with no drops.
